axil_order_slave: RTL and testbench
===================================

AXIL_ORDER_SLAVE -- requirements
Module: axil_order_slave

Interface
REQ-001 SHALL have parameter AXIL_DATA_WIDTH, default 32, meaning AXI-Lite data width (only 32 supported).
REQ-002 SHALL have parameter AXIL_ADDR_WIDTH, default 8, meaning AXI-Lite byte address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning instruction FIFO entries (power of two, 2..64).
REQ-004 s00_axi_aclk  in  1  single clock; all logic rises on its posedge.
REQ-005 s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 s00_axi_awaddr/awprot/awvalid  in  8/3/1; s00_axi_awready out 1 -- write address channel; awprot ignored.
REQ-007 s00_axi_wdata/wstrb/wvalid  in  32/4/1; s00_axi_wready out 1 -- write data channel.
REQ-008 s00_axi_bresp out 2, s00_axi_bvalid out 1, s00_axi_bready in 1 -- write response.
REQ-009 s00_axi_araddr/arprot/arvalid  in  8/3/1; s00_axi_arready out 1 -- read address; arprot ignored.
REQ-010 s00_axi_rdata out 32, s00_axi_rresp out 2, s00_axi_rvalid out 1, s00_axi_rready in 1 -- read data.
REQ-011 cfg_regs  out  512  config registers 0..15 concatenated, reg k at [32k+31:32k].
REQ-012 start_pulse  out  1  one-cycle pulse on control write.
REQ-013 order_valid out 1, order_data out 32, order_ready in 1 -- instruction stream to accelerator.

Function
REQ-014 Map (addr[7:2] decodes, addr[1:0] ignored) SHALL be: 0x00-0x3C cfg reg RW; 0x40 control WO; 0x44 FIFO count RO; 0x48 instruction push WO; 0x4C status RO; >=0x50 unmapped.
REQ-015 Write FSM SHALL have states W_IDLE, W_EXEC, W_RESP.
REQ-016 In W_IDLE awready SHALL be 1 until AW latched, wready 1 until W latched; channels accepted in either order or same cycle; go to W_EXEC the cycle after both latched.
REQ-017 W_EXEC SHALL commit exactly once then go to W_RESP with bvalid=1 next cycle; no-stall latency: last AW/W handshake at edge N -> bvalid high after edge N+2.
REQ-018 Cfg write SHALL update only bytes with wstrb bit set.
REQ-019 Control write with wdata[0]=1 and wstrb[0]=1 SHALL assert start_pulse for exactly one cycle at commit; control/0x44/0x4C/0x48 reads of WO regs return 0.
REQ-020 0x48 write SHALL push full wdata (wstrb ignored) into FIFO; if FIFO full, FSM SHALL stay in W_EXEC (stall) until space, never dropping data.
REQ-021 Writes to RO or unmapped addresses SHALL have no effect; bresp 2'b10 for unmapped, 2'b00 otherwise.
REQ-022 W_RESP SHALL hold bvalid/bresp stable until bready, then return to W_IDLE.
REQ-023 Read FSM: R_IDLE arready=1; on AR handshake at edge N, rdata/rresp captured from state at that edge, rvalid=1 after edge N; hold stable until rready, then R_IDLE.
REQ-024 Reads: cfg returns reg; 0x44 returns count zero-extended; 0x4C returns {30'b0, empty, not_full}; unmapped returns 0 with rresp 2'b10.
REQ-025 FIFO SHALL be first-word fall-through: order_valid = !empty, order_data = head; pop on order_valid&order_ready.
REQ-026 Push allowed only when count<FIFO_DEPTH (pre-pop count); simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 Read and write FSMs SHALL operate independently and concurrently.

Reset
REQ-028 On aresetn low: awready, wready, bvalid, arready, rvalid, start_pulse, order_valid SHALL be 0; bresp, rresp, rdata, all cfg regs, FIFO count/pointers 0; FSMs W_IDLE/R_IDLE.
REQ-029 Reset mid-transaction SHALL abandon it with no commit; arready, awready, wready go to 1 the first cycle after deassertion.

Verification
REQ-030 AW(0x04) and W(0xA5A5A5A5, strb 0xF) same cycle, then W(0x00FF0000, strb 0x4) -> cfg_regs[63:32]=0xA5FFA5A5, bresp 00 both.
REQ-031 W before AW by 3 cycles to 0x48 data 0x12345678 -> order_valid=1, order_data=0x12345678; read 0x44 -> 1.
REQ-032 order_ready=0, push 9 instructions -> 8 complete, 9th bvalid withheld; read 0x4C -> 0x0; pulse order_ready 1 cycle -> 9th bvalid follows, count stays 8.
REQ-033 Write 0x40 data 1 -> start_pulse high exactly 1 cycle; read 0x40 -> 0.
REQ-034 Write/read 0x60 -> bresp 10, rresp 10, rdata 0, no register change.
REQ-035 Assert aresetn low during W_RESP with bvalid=1 -> bvalid 0 immediately, cfg regs 0, FIFO empty (0x4C reads 0x3).

Source files
------------

// File: rtl/axil_order_slave.sv
// AXI-Lite slave with 16 config registers, a control strobe and an instruction
// FIFO streamed to an accelerator; independent read and write channel FSMs.
//
// state  | meaning
// W_IDLE | accepting AW and W (either order); both latched -> W_EXEC
// W_EXEC | commit the write; a push into a full FIFO waits here
// W_RESP | bvalid/bresp held until bready
// R_IDLE | arready high; read data captured on the AR handshake
// R_DATA | rvalid/rdata/rresp held until rready
module axil_order_slave #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [AXIL_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [AXIL_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [16*AXIL_DATA_WIDTH-1:0]  cfg_regs,
  output logic                           start_pulse,
  output logic                           order_valid,
  output logic [AXIL_DATA_WIDTH-1:0]     order_data,
  input  logic                           order_ready
);
  localparam int DW = AXIL_DATA_WIDTH;
  localparam int SW = AXIL_DATA_WIDTH / 8;
  localparam int WA = AXIL_ADDR_WIDTH - 2;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [WA-1:0] A_CTRL = WA'(16);
  localparam logic [WA-1:0] A_CNT  = WA'(17);
  localparam logic [WA-1:0] A_PUSH = WA'(18);
  localparam logic [WA-1:0] A_STAT = WA'(19);
  localparam logic [WA-1:0] A_END  = WA'(20);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic          aw_done, w_done, w_commit;
  logic [WA-1:0] aw_word;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [DW-1:0] cfg_q [16];
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WA-1:0] ar_word;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // ---------------- write FSM ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) w_state <= W_IDLE;
    else                  w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_done && w_done) w_next = W_EXEC;
      W_EXEC:  if (w_commit)          w_next = W_RESP;
      W_RESP:  if (s00_axi_bready)    w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Ready lines are gated by reset so they read low while it is held.
  always_comb begin
    s00_axi_awready = s00_axi_aresetn && (w_state == W_IDLE) && !aw_done;
    s00_axi_wready  = s00_axi_aresetn && (w_state == W_IDLE) && !w_done;
    s00_axi_bvalid  = (w_state == W_RESP);
    w_commit        = (w_state == W_EXEC) && !((aw_word == A_PUSH) && fifo_full);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_word       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s00_axi_bresp <= 2'b00;
      start_pulse   <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_done <= 1'b1;
        aw_word <= s00_axi_awaddr[AXIL_ADDR_WIDTH-1:2];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_done  <= 1'b1;
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (w_commit) begin
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
        s00_axi_bresp <= (aw_word >= A_END) ? 2'b10 : 2'b00;
        start_pulse   <= (aw_word == A_CTRL) && wdata_q[0] && wstrb_q[0];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < 16; k++) cfg_q[k] <= '0;
    end else if (w_commit && (aw_word < A_CTRL)) begin
      for (int b = 0; b < SW; b++)
        if (wstrb_q[b]) cfg_q[aw_word[3:0]][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int k = 0; k < 16; k++) cfg_regs[DW*k +: DW] = cfg_q[k];
  end

  // ---------------- instruction FIFO (first-word fall-through) ----------------
  assign fifo_full   = (fifo_count == (CW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_push   = w_commit && (aw_word == A_PUSH);
  assign fifo_pop    = order_valid && order_ready;
  assign order_valid = !fifo_empty;
  assign order_data  = fifo_mem[rd_ptr];

  always_ff @(posedge s00_axi_aclk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= wdata_q;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= R_IDLE;
    else                  r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s00_axi_arvalid) r_next = R_DATA;
      R_DATA:  if (s00_axi_rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s00_axi_arready = s00_axi_aresetn && (r_state == R_IDLE);
    s00_axi_rvalid  = (r_state == R_DATA);
  end

  assign ar_word = s00_axi_araddr[AXIL_ADDR_WIDTH-1:2];

  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    if (ar_word < A_CTRL)       rd_data = cfg_q[ar_word[3:0]];
    else if (ar_word == A_CNT)  rd_data = DW'(fifo_count);
    else if (ar_word == A_STAT) rd_data = DW'({fifo_empty, !fifo_full});
    else if (ar_word >= A_END)  rd_resp = 2'b10;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rdata <= '0;
      s00_axi_rresp <= 2'b00;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rdata <= rd_data;
      s00_axi_rresp <= rd_resp;
    end
  end
endmodule

// File: tb/tb_axil_order_slave.sv
// Directed bench for axil_order_slave: scoreboard queues hold expected write
// responses, read data and instruction words, compared when the DUT produces them.
module tb_axil_order_slave;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, order_data;
  logic [511:0] cfg_regs;
  logic         start_pulse, order_valid;
  logic         order_ready = 0;

  int checks = 0;
  int errors = 0;
  int sp_cnt = 0;
  logic [1:0]   b_q [$];
  logic [33:0]  r_q [$];
  logic [31:0]  o_q [$];
  logic [511:0] cfg_m = '0;

  always #5 clk = ~clk;
  always @(negedge clk) if (start_pulse === 1'b1) sp_cnt++;

  axil_order_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .cfg_regs(cfg_regs), .start_pulse(start_pulse),
    .order_valid(order_valid), .order_data(order_data), .order_ready(order_ready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] a, input int dly);
    bit hs = 0;
    repeat (dly) tick();
    awaddr = a;
    awvalid = 1;
    for (int i = 0; i < 40 && !hs; i++) begin
      hs = awready;
      tick();
    end
    awvalid = 0;
    chk("aw_handshake", hs, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs = 0;
    repeat (dly) tick();
    wdata = d;
    wstrb = s;
    wvalid = 1;
    for (int i = 0; i < 40 && !hs; i++) begin
      hs = wready;
      tick();
    end
    wvalid = 0;
    chk("w_handshake", hs, 1);
  endtask

  task automatic write_req(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    b_q.push_back(exp_resp);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
  endtask

  // exp_lat < 0 skips the latency check (used after a stall).
  task automatic wait_b(input string tag, input bit do_ready, input int exp_lat);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bvalid) begin
        seen = 1;
        break;
      end
      tick();
      lat++;
    end
    chk({tag, "_bvalid"}, seen, 1);
    if (seen) begin
      chk({tag, "_bresp"}, bresp, b_q.pop_front());
      if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
      if (do_ready) begin
        bready = 1;
        tick();
        bready = 0;
      end
    end
  endtask

  task automatic read_req(input string tag, input logic [7:0] a, input logic [1:0] er, input logic [31:0] ed);
    bit hs = 0;
    logic [33:0] e;
    r_q.push_back({er, ed});
    araddr = a;
    arvalid = 1;
    for (int i = 0; i < 40 && !hs; i++) begin
      hs = arready;
      tick();
    end
    arvalid = 0;
    chk({tag, "_ar_handshake"}, hs, 1);
    chk({tag, "_rvalid"}, rvalid, 1);
    e = r_q.pop_front();
    chk({tag, "_rdata"}, rdata, e[31:0]);
    chk({tag, "_rresp"}, rresp, e[33:32]);
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic pop_order(input string tag);
    chk({tag, "_valid"}, order_valid, 1);
    chk({tag, "_data"}, order_data, o_q.pop_front());
    order_ready = 1;
    tick();
    order_ready = 0;
  endtask

  initial begin
    int sp0;
    tick();
    tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_start", start_pulse, 0);
    chk("rst_order_valid", order_valid, 0);
    chk("rst_cfg", cfg_regs, cfg_m);
    chk("rst_resp", {bresp, rresp, rdata}, 0);
    rstn = 1;
    tick();
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    // byte-strobed config writes, AW and W in the same cycle
    write_req(8'h04, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b00);
    wait_b("cfg_full", 1, 2);
    cfg_m[63:32] = 32'hA5A5A5A5;
    write_req(8'h04, 32'h00FF0000, 4'h4, 0, 0, 2'b00);
    wait_b("cfg_strb", 1, 2);
    cfg_m[55:48] = 8'hFF;
    chk("cfg1_value", cfg_regs[63:32], 32'hA5FFA5A5);
    chk("cfg_all", cfg_regs, cfg_m);

    // AW ahead of W, last config register, partial strobe
    write_req(8'h3C, 32'hDEADBEEF, 4'h3, 0, 2, 2'b00);
    wait_b("cfg15", 1, 2);
    cfg_m[495:480] = 16'hBEEF;
    chk("cfg15_all", cfg_regs, cfg_m);
    read_req("rd_cfg15", 8'h3C, 2'b00, 32'h0000BEEF);
    read_req("rd_cfg1_lowbits", 8'h07, 2'b00, 32'hA5FFA5A5);

    // W ahead of AW by 3 cycles into the instruction FIFO (strobe ignored)
    o_q.push_back(32'h12345678);
    write_req(8'h48, 32'h12345678, 4'h0, 3, 0, 2'b00);
    wait_b("push1", 1, 2);
    chk("push1_order_valid", order_valid, 1);
    chk("push1_order_data", order_data, o_q[0]);
    read_req("rd_count1", 8'h44, 2'b00, 32'd1);
    pop_order("pop1");
    chk("pop1_empty", order_valid, 0);

    // fill the FIFO, ninth push stalls until one entry drains
    for (int k = 0; k < 8; k++) begin
      o_q.push_back(32'hC0DE0000 + k);
      write_req(8'h48, 32'hC0DE0000 + k, 4'hF, 0, 0, 2'b00);
      wait_b("push_fill", 1, 2);
    end
    o_q.push_back(32'hC0DE0008);
    write_req(8'h48, 32'hC0DE0008, 4'hF, 0, 0, 2'b00);
    repeat (8) tick();
    chk("full_stall_bvalid", bvalid, 0);
    read_req("rd_stat_full", 8'h4C, 2'b00, 32'h0);
    read_req("rd_count_full", 8'h44, 2'b00, 32'd8);
    pop_order("pop_release");
    wait_b("push_after_stall", 1, -1);
    read_req("rd_count_refill", 8'h44, 2'b00, 32'd8);
    for (int k = 0; k < 8; k++) pop_order("drain");
    chk("drain_empty", order_valid, 0);
    read_req("rd_stat_empty", 8'h4C, 2'b00, 32'h3);

    // control strobe
    sp0 = sp_cnt;
    write_req(8'h40, 32'h1, 4'h1, 0, 0, 2'b00);
    wait_b("ctrl", 1, 2);
    repeat (3) tick();
    chk("start_pulse_once", sp_cnt - sp0, 1);
    chk("start_pulse_low", start_pulse, 0);
    read_req("rd_ctrl", 8'h40, 2'b00, 32'h0);
    sp0 = sp_cnt;
    write_req(8'h40, 32'h1, 4'h2, 0, 0, 2'b00);
    wait_b("ctrl_nostrb", 1, 2);
    repeat (2) tick();
    chk("start_pulse_strb0", sp_cnt - sp0, 0);

    // unmapped and read-only targets
    write_req(8'h60, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    wait_b("wr_unmapped", 1, 2);
    read_req("rd_unmapped", 8'h60, 2'b10, 32'h0);
    write_req(8'h50, 32'hFFFFFFFF, 4'hF, 1, 0, 2'b10);
    wait_b("wr_0x50", 1, 2);
    read_req("rd_0x50", 8'h50, 2'b10, 32'h0);
    write_req(8'h44, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00);
    wait_b("wr_ro_count", 1, 2);
    write_req(8'h4C, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00);
    wait_b("wr_ro_status", 1, 2);
    chk("ro_unmapped_cfg", cfg_regs, cfg_m);
    chk("ro_unmapped_fifo", order_valid, 0);
    read_req("rd_stat_after_ro", 8'h4C, 2'b00, 32'h3);

    // reset while a response is pending
    write_req(8'h08, 32'h11223344, 4'hF, 0, 0, 2'b00);
    wait_b("pre_cfg2", 1, 2);
    cfg_m[95:64] = 32'h11223344;
    o_q.push_back(32'h55);
    write_req(8'h48, 32'h55, 4'hF, 0, 0, 2'b00);
    wait_b("pre_push", 1, 2);
    chk("pre_rst_cfg", cfg_regs, cfg_m);
    write_req(8'h0C, 32'h77, 4'hF, 0, 0, 2'b00);
    wait_b("pre_reset", 0, 2);
    #2;
    rstn = 0;
    #1;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_cfg", cfg_regs, 0);
    chk("midrst_order_valid", order_valid, 0);
    chk("midrst_awready", awready, 0);
    cfg_m = '0;
    o_q.delete();
    tick();
    rstn = 1;
    tick();
    chk("after_rst_ready", {awready, wready, arready}, 3'b111);
    read_req("rd_stat_after_rst", 8'h4C, 2'b00, 32'h3);
    read_req("rd_count_after_rst", 8'h44, 2'b00, 32'h0);
    read_req("rd_cfg3_after_rst", 8'h0C, 2'b00, 32'h0);
    chk("after_rst_cfg", cfg_regs, cfg_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
